// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the serial shift sequencing controller:
// FSM state encoding and a counter-width helper that never returns zero.
package shift_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A counter for n states needs at least one bit even when n == 1.
    function automatic int safe_clog2(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_tick_gen.sv
// Shift-rate divider: while en is high, tick fires on every DIV-th cycle.
// The count restarts from zero whenever en is low.
module shift_tick_gen
    import shift_seq_ctrl_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            CW   = safe_clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_divcnt;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_divcnt <= '0;
        end else if (r_divcnt == LAST) begin
            r_divcnt <= '0;
        end else begin
            r_divcnt <= r_divcnt + 1'b1;
        end
    end

    assign tick = en && (r_divcnt == LAST);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Full-duplex serial shift controller: loads a word on start, shifts it out
// MSB-first while shifting sin in, then pulses done and publishes rx_data.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             sin,
    output logic             sout,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data
);

    localparam int            BW       = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shreg;
    logic [BW-1:0]    r_bitcnt;
    logic [WIDTH-1:0] r_rx_data;
    logic             w_shift_active;
    logic             w_tick;
    logic             w_last_shift;
    logic [WIDTH-1:0] w_shreg_next;

    assign w_shift_active = (r_state == SHIFT);
    assign w_shreg_next   = {r_shreg[WIDTH-2:0], sin};
    assign w_last_shift   = w_tick && (r_bitcnt == LAST_BIT);

    shift_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (w_shift_active),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg   <= '0;
            r_bitcnt  <= '0;
            r_rx_data <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_shreg  <= tx_data;
                r_bitcnt <= '0;
            end else if (w_tick) begin
                r_shreg  <= w_shreg_next;
                r_bitcnt <= w_last_shift ? '0 : r_bitcnt + 1'b1;
                if (w_last_shift) begin
                    r_rx_data <= w_shreg_next;
                end
            end
        end
    end

    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != IDLE);
        done         = (r_state == DONE);
        shift_en     = w_tick;
        sout         = busy ? r_shreg[WIDTH-1] : 1'b0;
        case (r_state)
            IDLE:    if (start) w_state_next = SHIFT;
            SHIFT:   if (w_last_shift) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign rx_data = r_rx_data;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench: stimulus queues expected shift bits and completions;
// a negedge monitor pops and compares whenever shift_en or done is seen.
module tb_shift_seq_ctrl;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start_a, start_b;
    logic [3:0] tx_a, tx_b;
    logic       loop_a, loop_b, sin_val_a, sin_val_b;
    logic       sin_a, sin_b;
    logic       sout_a, shift_en_a, busy_a, done_a;
    logic       sout_b, shift_en_b, busy_b, done_b;
    logic [3:0] rx_a, rx_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sq_a[$], dq_a[$], sq_b[$], dq_b[$];

    assign sin_a = loop_a ? sout_a : sin_val_a;
    assign sin_b = loop_b ? sout_b : sin_val_b;

    shift_seq_ctrl #(.WIDTH(4), .DIV(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .tx_data(tx_a), .sin(sin_a),
        .sout(sout_a), .shift_en(shift_en_a), .busy(busy_a), .done(done_a), .rx_data(rx_a)
    );

    shift_seq_ctrl #(.WIDTH(4), .DIV(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b), .sin(sin_b),
        .sout(sout_b), .shift_en(shift_en_b), .busy(busy_b), .done(done_b), .rx_data(rx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected serial bits (MSB first, one per shift) and the completion.
    task automatic push_exp(input bit to_b, input logic [3:0] tx, input logic [3:0] rx,
                            input int c0, input int div);
        exp_t e;
        for (int k = 1; k <= 4; k++) begin
            e.cyc = c0 + k * div;
            e.val = {3'b000, tx[4-k]};
            if (to_b) sq_b.push_back(e); else sq_a.push_back(e);
        end
        e.cyc = c0 + 4 * div + 1;
        e.val = rx;
        if (to_b) dq_b.push_back(e); else dq_a.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (shift_en_a) begin
            check("a_shift_pending", 32'(sq_a.size() != 0), 1);
            if (sq_a.size() != 0) begin
                e = sq_a.pop_front();
                check("a_shift_cycle", cyc, e.cyc);
                check("a_sout", sout_a, e.val);
            end
        end
        if (done_a) begin
            check("a_done_pending", 32'(dq_a.size() != 0), 1);
            if (dq_a.size() != 0) begin
                e = dq_a.pop_front();
                check("a_done_cycle", cyc, e.cyc);
                check("a_rx_data", rx_a, e.val);
            end
        end
        if (shift_en_b) begin
            check("b_shift_pending", 32'(sq_b.size() != 0), 1);
            if (sq_b.size() != 0) begin
                e = sq_b.pop_front();
                check("b_shift_cycle", cyc, e.cyc);
                check("b_sout", sout_b, e.val);
            end
        end
        if (done_b) begin
            check("b_done_pending", 32'(dq_b.size() != 0), 1);
            if (dq_b.size() != 0) begin
                e = dq_b.pop_front();
                check("b_done_cycle", cyc, e.cyc);
                check("b_rx_data", rx_b, e.val);
            end
        end
    end

    initial begin
        int c0;
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        tx_a = 4'h0; tx_b = 4'h0;
        loop_a = 1'b1; loop_b = 1'b1;
        sin_val_a = 1'b0; sin_val_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_sout", sout_a, 0);
        check("rst_shift_en", shift_en_a, 0);
        check("rst_rx_data", rx_a, 0);
        check("rst_busy_b", busy_b, 0);
        rst = 1'b0;
        @(negedge clk);

        // Loopback 1010, DIV=1.
        c0 = cyc;
        start_a = 1'b1; tx_a = 4'b1010;
        push_exp(0, 4'b1010, 4'b1010, c0, 1);
        @(negedge clk);
        start_a = 1'b0;
        wait_to(c0 + 5);
        check("lb_busy_done_cycle", busy_a, 1);
        wait_to(c0 + 6);
        check("lb_busy_after", busy_a, 0);
        check("lb_rx_held", rx_a, 4'b1010);
        check("lb_sout_idle", sout_a, 0);

        // All-zero word out, constant 1 in.
        loop_a = 1'b0; sin_val_a = 1'b1;
        c0 = cyc;
        start_a = 1'b1; tx_a = 4'b0000;
        push_exp(0, 4'b0000, 4'b1111, c0, 1);
        @(negedge clk);
        start_a = 1'b0;
        wait_to(c0 + 6);
        check("ones_rx", rx_a, 4'b1111);
        loop_a = 1'b1;

        // Starts while busy are dropped; the first IDLE-cycle start is taken.
        c0 = cyc;
        push_exp(0, 4'b1001, 4'b1001, c0, 1);
        push_exp(0, 4'b0110, 4'b0110, c0 + 6, 1);
        for (int i = 0; i <= 12; i++) begin
            wait_to(c0 + i);
            if (i == 6) check("ign_busy_c6", busy_a, 0);
            if (i == 7) check("ign_busy_c7", busy_a, 1);
            start_a = (i == 0 || i == 2 || i == 5 || i == 6);
            tx_a    = (i == 0) ? 4'b1001 : 4'b0110;
        end
        start_a = 1'b0;

        // Back-to-back transfers.
        c0 = cyc;
        push_exp(0, 4'b0011, 4'b0011, c0, 1);
        push_exp(0, 4'b0101, 4'b0101, c0 + 6, 1);
        for (int i = 0; i <= 12; i++) begin
            wait_to(c0 + i);
            if (i == 10) check("b2b_rx_hold", rx_a, 4'b0011);
            if (i == 12) check("b2b_rx_new", rx_a, 4'b0101);
            if (i == 12) check("b2b_busy_end", busy_a, 0);
            start_a = (i == 0 || i == 6);
            tx_a    = (i == 0) ? 4'b0011 : 4'b0101;
        end
        start_a = 1'b0;

        // Reset on cycle 3 aborts: no done, rx cleared, no further shifts.
        c0 = cyc;
        start_a = 1'b1; tx_a = 4'b1111;
        for (int k = 1; k <= 3; k++) sq_a.push_back('{cyc: c0 + k, val: 4'b0001});
        @(negedge clk);
        start_a = 1'b0;
        wait_to(c0 + 3);
        rst = 1'b1;
        wait_to(c0 + 4);
        rst = 1'b0;
        check("abort_busy", busy_a, 0);
        check("abort_sout", sout_a, 0);
        check("abort_rx", rx_a, 0);
        check("abort_done", done_a, 0);
        wait_to(c0 + 14);
        check("abort_idle", busy_a, 0);

        // DIV=3 loopback 1100.
        c0 = cyc;
        start_b = 1'b1; tx_b = 4'b1100;
        push_exp(1, 4'b1100, 4'b1100, c0, 3);
        @(negedge clk);
        start_b = 1'b0;
        tx_b = 4'b0011;
        wait_to(c0 + 14);
        check("div3_busy_after", busy_b, 0);
        check("div3_rx_held", rx_b, 4'b1100);

        repeat (3) @(negedge clk);
        check("sq_a_drained", sq_a.size(), 0);
        check("dq_a_drained", dq_a.size(), 0);
        check("sq_b_drained", sq_b.size(), 0);
        check("dq_b_drained", dq_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencing controller for the team's serial shift-register datapath. It accepts a parallel word on a start pulse and shifts it out MSB-first on a serial line. At the same time it shifts the serial input in, giving full-duplex loopback-capable operation. A programmable clock-enable divider sets the shift rate, and busy/done handshake with the requester.

Parameters:
WIDTH, 4, shift-register length in bits (>=2)
DIV, 1, clk cycles per shift (>=1); a shift occurs every DIV-th cycle of SHIFT

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
tx_data  input  WIDTH  parallel word to transmit; captured on accepted start
sin  input  1  serial input, sampled on each shift edge
sout  output  1  serial output = shreg[WIDTH-1] while busy, 0 otherwise
shift_en  output  1  high in each cycle whose closing edge performs a shift
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, transfer complete
rx_data  output  WIDTH  last completed received word; held until next completion

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; shreg, bit counter, divider counter, rx_data = 0. Consequently sout=0, shift_en=0, busy=0, done=0. rst overrides every other input.
- States: IDLE, SHIFT, DONE. Encoding comes from the shared package.
- IDLE: if start=1, then shreg<=tx_data, bitcnt<=0, divcnt<=0, next=SHIFT. Otherwise hold.
- SHIFT: divcnt counts 0..DIV-1 and wraps to 0. shift_en = (state==SHIFT && divcnt==DIV-1). With DIV=1, shift_en is high every SHIFT cycle.
- On a shift_en edge: shreg<={shreg[WIDTH-2:0], sin}; bitcnt++.
- On the shift_en edge with bitcnt==WIDTH-1: rx_data<={shreg[WIDTH-2:0], sin}, next=DONE.
- DONE: done=1 for exactly this one cycle, next=IDLE unconditionally. start is ignored in DONE.
- Timing: start sampled at cycle 0. busy is high on cycles 1..WIDTH*DIV+1. shift_en is high on cycles k*DIV for k=1..WIDTH. done is high on cycle WIDTH*DIV+1. A new start is accepted on cycle WIDTH*DIV+2 at the earliest.
- start while busy (SHIFT or DONE): ignored, not queued. tx_data changes during SHIFT have no effect.
- Reset mid-transfer: immediate abort on that edge. No done pulse; rx_data is cleared to 0.
- Counter widths: bitcnt is $clog2(WIDTH) bits; divcnt is max(1,$clog2(DIV)) bits. Both wrap only via the explicit compare, never by overflow.
- Bit order: MSB transmitted first; the first received bit lands in rx_data[WIDTH-1].

Decomposition:
- Shared package/header: state encoding localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the clog2-safe width helper.
- One sub-module, shift_tick_gen: a DIV-parameterised divider with inputs clk, rst, en (=state==SHIFT) and a tick output. shift_en comes from tick.
- FSM, bit counter and shift register stay in shift_seq_ctrl.

Test Plan:
- WIDTH=4, DIV=1, sin tied to sout, start with tx_data=4'b1010 at cycle 0 -> sout 1,0,1,0 on cycles 1-4; shift_en high cycles 1-4; done only on cycle 5; rx_data=4'b1010 from cycle 6; busy low at cycle 6.
- WIDTH=4, DIV=1, tx_data=4'b0000, sin=1 constant -> sout 0,0,0,0; rx_data=4'b1111 after done.
- WIDTH=4, DIV=3, tx_data=4'b1100 looped back -> shift_en only on cycles 3,6,9,12; done on cycle 13; rx_data=4'b1100.
- Start at cycle 0 (tx_data=4'b1001), then start with tx_data=4'b0110 on cycles 2 and 5 (DIV=1) -> second request ignored; rx_data=4'b1001 (loopback). Start on cycle 6 is accepted; busy rises on cycle 7.
- rst=1 on cycle 3 of a DIV=1 transfer -> cycle 4: busy=0, sout=0, rx_data=0; no done pulse at any later cycle without a new start.
- Back-to-back: second start on the first IDLE cycle after done -> new transfer completes correctly; rx_data updates only at the second done.
